// File: rtl/vga_pkg.sv
// Shared video constants and small helpers for the pong datapath.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PADDLE_H = 64;
  localparam int STEP     = 4;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Requested paddle motion for one frame.
  typedef enum logic [1:0] {
    MOVE_HOLD = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } move_t;

  // Opposing buttons cancel each other out.
  function automatic move_t decode_move(input logic up, input logic down);
    move_t m;
    m = MOVE_HOLD;
    if (up && !down) begin
      m = MOVE_UP;
    end else if (down && !up) begin
      m = MOVE_DOWN;
    end
    return m;
  endfunction

endpackage

// File: rtl/paddle_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a window debouncer for one raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 252000
) (
  input  logic clk_25,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          db_reg;
  logic          synced;

  assign synced = sync_reg[1];
  assign db     = db_reg;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], raw};
    end
  end

  // Count an uninterrupted disagreement window; any bounce back restarts it.
  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      db_reg  <= 1'b0;
    end else if (synced == db_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == TERM) begin
      cnt_reg <= '0;
      db_reg  <= ~db_reg;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Button conditioning, vsync edge detection and once-per-frame paddle stepping.
module paddle_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 252000,
  parameter int V_ACTIVE         = vga_pkg::V_ACTIVE,
  parameter int PADDLE_H         = vga_pkg::PADDLE_H,
  parameter int STEP             = vga_pkg::STEP,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic               btn_up_raw,
  input  logic               btn_down_raw,
  input  logic               vsync,
  output logic [COORD_W-1:0] paddle_y,
  output logic               frame_pulse,
  output logic               btn_up_db,
  output logic               btn_down_db
);

  localparam int          MAX_Y   = V_ACTIVE - PADDLE_H;
  localparam logic [10:0] MAX_W   = 11'(MAX_Y);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam coord_t      RESET_Y = coord_t'(MAX_Y / 2);

  logic   vsync_q;
  logic   frame_pulse_reg;
  coord_t paddle_y_reg;
  coord_t paddle_y_next;
  logic   vsync_on;
  logic   vsync_q_on;
  move_t  move;
  logic [10:0] y_ext;

  // Identical debouncers for both buttons.
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_25 (clk_25),
    .rst    (rst),
    .raw    (btn_up_raw),
    .db     (btn_up_db)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk_25 (clk_25),
    .rst    (rst),
    .raw    (btn_down_raw),
    .db     (btn_down_db)
  );

  // Normalise polarity so "on" means vsync is asserted.
  assign vsync_on   = vsync ^ VSYNC_ACTIVE_LOW;
  assign vsync_q_on = vsync_q ^ VSYNC_ACTIVE_LOW;

  // Strobe once on the asserting edge; vsync_q resets to idle so release cannot fire it.
  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      vsync_q         <= VSYNC_ACTIVE_LOW;
      frame_pulse_reg <= 1'b0;
    end else begin
      vsync_q         <= vsync;
      frame_pulse_reg <= vsync_on & ~vsync_q_on;
    end
  end

  // Saturating step in 11-bit arithmetic so neither end can wrap.
  always_comb begin
    paddle_y_next = paddle_y_reg;
    y_ext         = {1'b0, paddle_y_reg};
    move          = decode_move(btn_up_db, btn_down_db);
    case (move)
      MOVE_UP: begin
        if (y_ext < STEP_W) begin
          paddle_y_next = '0;
        end else begin
          paddle_y_next = coord_t'(y_ext - STEP_W);
        end
      end
      MOVE_DOWN: begin
        if (y_ext > (MAX_W - STEP_W)) begin
          paddle_y_next = coord_t'(MAX_W);
        end else begin
          paddle_y_next = coord_t'(y_ext + STEP_W);
        end
      end
      default: paddle_y_next = paddle_y_reg;
    endcase
  end

  // Position only moves on the strobe, so it is stable for the whole visible frame.
  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      paddle_y_reg <= RESET_Y;
    end else if (frame_pulse_reg) begin
      paddle_y_reg <= paddle_y_next;
    end
  end

  assign paddle_y    = paddle_y_reg;
  assign frame_pulse = frame_pulse_reg;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl with a short debounce window.
`timescale 1ns/1ps
module tb_paddle_ctrl;

  localparam int MAXY  = 416;
  localparam int STEPV = 4;
  localparam int RSTY  = 208;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic       vsync = 1'b1;
  logic [9:0] paddle_y;
  logic       frame_pulse;
  logic       btn_up_db;
  logic       btn_down_db;

  paddle_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_25       (clk_25),
    .rst          (rst),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .vsync        (vsync),
    .paddle_y     (paddle_y),
    .frame_pulse  (frame_pulse),
    .btn_up_db    (btn_up_db),
    .btn_down_db  (btn_down_db)
  );

  always #5 clk_25 = ~clk_25;

  int cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  typedef struct {
    int k;
    bit up;
    bit down;
    int y;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Model: a debounced level follows its raw level once the raw level has
  // been stable from its first sampling edge c through edge c+5.
  bit raw_m[2];
  bit old_m[2];
  int chg_m[2];
  int y_m = RSTY;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit exp_db(input int b, input int k);
    return (k >= chg_m[b] + 5) ? raw_m[b] : old_m[b];
  endfunction

  function automatic int model_step(input int y, input bit u, input bit d);
    if (u && !d) return (y < STEPV) ? 0 : y - STEPV;
    if (d && !u) return (y + STEPV > MAXY) ? MAXY : y + STEPV;
    return y;
  endfunction

  task automatic model_btn(input int b, input bit v);
    if (v != raw_m[b]) begin
      old_m[b] = exp_db(b, cyc);
      raw_m[b] = v;
      chg_m[b] = cyc + 1;
    end
  endtask

  // Called just after a falling clock edge.
  task automatic set_btn(input bit u, input bit d);
    model_btn(0, u);
    model_btn(1, d);
    btn_up_raw   = u;
    btn_down_raw = d;
  endtask

  task automatic model_reset();
    old_m[0] = 1'b0;
    old_m[1] = 1'b0;
    chg_m[0] = raw_m[0] ? cyc + 1 : -100;
    chg_m[1] = raw_m[1] ? cyc + 1 : -100;
    y_m      = RSTY;
  endtask

  // Drive one vsync pulse and queue the response it must produce.
  task automatic do_frame(input int lo, input int hi);
    exp_t e;
    e.k    = cyc + 1;
    e.up   = exp_db(0, e.k);
    e.down = exp_db(1, e.k);
    y_m    = model_step(y_m, e.up, e.down);
    e.y    = y_m;
    sbq.push_back(e);
    vsync = 1'b0;
    repeat (lo) @(negedge clk_25);
    vsync = 1'b1;
    repeat (hi) @(negedge clk_25);
  endtask

  // Monitor: paddle_y must hold every cycle except the one after a strobe.
  int   cur_y = RSTY;
  int   pend_y = RSTY;
  bit   upd = 1'b0;
  exp_t mon_e;
  always @(negedge clk_25) begin
    if (!rst) begin
      cur_y = RSTY;
      upd   = 1'b0;
    end else begin
      if (upd) begin
        cur_y = pend_y;
        upd   = 1'b0;
      end
      check("paddle_y", int'(paddle_y), cur_y);
      if (frame_pulse) begin
        if (sbq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          $display("frame at cycle %0d: up_db=%0d down_db=%0d -> y=%0d", cyc, btn_up_db, btn_down_db, mon_e.y);
          check("pulse_cycle", cyc, mon_e.k);
          check("up_db_at_pulse", int'(btn_up_db), int'(mon_e.up));
          check("down_db_at_pulse", int'(btn_down_db), int'(mon_e.down));
          pend_y = mon_e.y;
          upd    = 1'b1;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    raw_m[0] = 1'b0;
    raw_m[1] = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk_25);
    check("rst_paddle_y", int'(paddle_y), RSTY);
    check("rst_frame_pulse", int'(frame_pulse), 0);
    check("rst_up_db", int'(btn_up_db), 0);
    check("rst_down_db", int'(btn_down_db), 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk_25);
    check("no_pulse_after_release", int'(frame_pulse), 0);

    // Debounce latency: raw edge to db in 2 + DEBOUNCE_CYCLES cycles
    set_btn(1'b1, 1'b0);
    n = 0;
    while (!btn_up_db && n < 20) begin
      @(negedge clk_25);
      n++;
    end
    check("db_latency", n, 6);
    set_btn(1'b0, 1'b0);
    repeat (10) @(negedge clk_25);
    check("db_release", int'(btn_up_db), 0);

    // Glitch: short high runs never complete the window
    btn_up_raw = 1'b1; repeat (2) @(negedge clk_25);
    btn_up_raw = 1'b0; repeat (2) @(negedge clk_25);
    btn_up_raw = 1'b1; repeat (2) @(negedge clk_25);
    btn_up_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_25);
      check("glitch_db", int'(btn_up_db), 0);
    end

    // Long vsync low gives a single strobe; rising edge gives none
    do_frame(20, 10);

    // Stepping down from reset position
    set_btn(1'b0, 1'b1);
    repeat (8) @(negedge clk_25);
    repeat (3) do_frame(2, 6);
    check("step_down_3", int'(paddle_y), 220);

    // Both held: no motion
    set_btn(1'b1, 1'b1);
    repeat (8) @(negedge clk_25);
    repeat (5) do_frame(3, 5);
    check("both_hold", int'(paddle_y), 220);

    // Up db falls on the edge ending the strobe cycle: old value used
    set_btn(1'b0, 1'b1);
    repeat (4) @(negedge clk_25);
    do_frame(2, 6);
    check("same_cycle_hold", int'(paddle_y), 220);
    do_frame(2, 6);
    check("next_frame_moves", int'(paddle_y), 224);

    // Saturation at both ends
    set_btn(1'b1, 1'b0);
    repeat (8) @(negedge clk_25);
    repeat (60) do_frame(2, 4);
    check("sat_top", int'(paddle_y), 0);
    set_btn(1'b0, 1'b1);
    repeat (8) @(negedge clk_25);
    repeat (110) do_frame(2, 4);
    check("sat_bottom", int'(paddle_y), MAXY);

    // Asynchronous reset mid-run with up held
    set_btn(1'b1, 1'b0);
    repeat (8) @(negedge clk_25);
    do_frame(2, 4);
    @(posedge clk_25);
    #2 rst = 1'b0;
    #1;
    check("midrst_paddle_y", int'(paddle_y), RSTY);
    check("midrst_frame_pulse", int'(frame_pulse), 0);
    check("midrst_up_db", int'(btn_up_db), 0);
    check("midrst_down_db", int'(btn_down_db), 0);
    repeat (2) @(negedge clk_25);
    rst = 1'b1;
    model_reset();
    @(negedge clk_25);
    check("midrst_no_pulse", int'(frame_pulse), 0);
    repeat (8) @(negedge clk_25);

    // Randomised frames against the model
    for (int i = 0; i < 40; i++) begin
      set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) @(negedge clk_25);
      do_frame($urandom_range(2, 5), $urandom_range(4, 8));
    end

    repeat (10) @(negedge clk_25);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
